// File: rtl/regfile_wb_arbiter_if.sv
// Writeback bus between the result-producing units and the register-file
// write port.
//
// Signals:
//   req_valid  per-requester write request
//   req_ready  per-requester accept, combinational from the arbiter
//   req_addr   flattened destination addresses, requester i at [i*ADDR_W +: ADDR_W]
//   req_data   flattened write data, requester i at [i*DATA_W +: DATA_W]
//   rf_wen     register-file write enable (registered)
//   rf_waddr   register-file write address (registered)
//   rf_wdata   register-file write data (registered)
//
// Modports:
//   master  the requester / register-file side (drives requests)
//   slave   the arbiter (accepts requests, drives the write port)
interface regfile_wb_arbiter_if #(
  parameter int NREQ   = 2,
  parameter int ADDR_W = 5,
  parameter int DATA_W = 64
);
  logic [NREQ-1:0]        req_valid;
  logic [NREQ-1:0]        req_ready;
  logic [NREQ*ADDR_W-1:0] req_addr;
  logic [NREQ*DATA_W-1:0] req_data;
  logic                   rf_wen;
  logic [ADDR_W-1:0]      rf_waddr;
  logic [DATA_W-1:0]      rf_wdata;

  modport master (
    output req_valid, req_addr, req_data,
    input  req_ready, rf_wen, rf_waddr, rf_wdata
  );

  modport slave (
    input  req_valid, req_addr, req_data,
    output req_ready, rf_wen, rf_waddr, rf_wdata
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the single register-file write port between
// NREQ writeback requesters (e.g. ALU and LSU result paths).
//
// After reset release the block stays in HOLD for exactly two rising edges
// (no grants) so no write can land on a register that is still being
// reset. In ARB the requester found first when scanning from the round-robin
// pointer wins; its write is registered and appears on the write port one
// cycle after acceptance. Writes to x0 are accepted but the write enable is
// suppressed. A saturating counter records cycles with contention.
//
// Ports:
//   clk       clock, rising edge
//   rst       asynchronous active-low reset (0 = reset)
//   bus       writeback interface, slave modport (requests in, write port out)
//   grant_id  index of the last accepted requester (registered)
//   busy_cnt  saturating count of ARB cycles with >= 2 valid requesters
module regfile_wb_arbiter #(
  parameter int NREQ   = 2,
  parameter int ADDR_W = 5,
  parameter int DATA_W = 64,
  parameter int CNT_W  = 16,
  localparam int IDW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  regfile_wb_arbiter_if.slave   bus,
  output logic [IDW-1:0]        grant_id,
  output logic [CNT_W-1:0]      busy_cnt
);

  localparam logic [IDW:0] NREQ_W = (IDW+1)'(NREQ);

  typedef enum logic {
    HOLD = 1'b0,
    ARB  = 1'b1
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [1:0]  hold_cnt;
  logic [1:0]  hold_nxt;

  logic [IDW-1:0]    ptr;
  logic [IDW-1:0]    ptr_nxt;
  logic [NREQ-1:0]   rot_p0;
  logic              found_p0;
  logic [IDW:0]      off_p0;
  logic [IDW:0]      sum_p0;
  logic [IDW:0]      inc_p0;
  logic [IDW-1:0]    win_p0;
  logic [NREQ-1:0]   ready_p0;
  logic              xfer_p0;
  logic [ADDR_W-1:0] addr_p0;
  logic [DATA_W-1:0] data_p0;
  logic [2:0]        pop_p0;
  logic              multi_p0;

  logic              vld_p1;
  logic [ADDR_W-1:0] addr_p1;
  logic [DATA_W-1:0] data_p1;
  logic [IDW-1:0]    grant_p1;
  logic [CNT_W-1:0]  busy_q;

  // Saturating increment: sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // FSM: state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= HOLD;
      hold_cnt <= 2'd2;
    end else begin
      state    <= state_nxt;
      hold_cnt <= hold_nxt;
    end
  end

  // FSM: next state. HOLD counts down from 2 and hands over to ARB on the
  // edge that takes the counter to 0.
  always_comb begin
    state_nxt = state;
    hold_nxt  = hold_cnt;
    if (state == HOLD) begin
      hold_nxt = hold_cnt - 2'd1;
      if (hold_cnt <= 2'd1) begin
        hold_nxt  = 2'd0;
        state_nxt = ARB;
      end
    end
  end

  // stage p0: round-robin grant selection
  // The valid vector is rotated so that bit 0 corresponds to ptr; the lowest
  // set bit of the rotated vector is the winner, offset back by ptr.
  always_comb begin
    rot_p0   = NREQ'({bus.req_valid, bus.req_valid} >> ptr);
    found_p0 = 1'b0;
    off_p0   = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (rot_p0[k]) begin
        found_p0 = 1'b1;
        off_p0   = (IDW+1)'(k);
      end
    end
    sum_p0 = {1'b0, ptr} + off_p0;
    if (sum_p0 >= NREQ_W) begin
      sum_p0 = sum_p0 - NREQ_W;
    end
    win_p0 = sum_p0[IDW-1:0];

    inc_p0 = {1'b0, win_p0} + (IDW+1)'(1);
    if (inc_p0 >= NREQ_W) begin
      inc_p0 = '0;
    end
    ptr_nxt = inc_p0[IDW-1:0];
  end

  // FSM: outputs. Ready is one-hot on the winner in ARB only; it depends on
  // req_valid but never on address or data.
  always_comb begin
    ready_p0 = '0;
    if (state == ARB && found_p0) begin
      for (int i = 0; i < NREQ; i++) begin
        ready_p0[i] = (win_p0 == IDW'(i));
      end
    end
  end

  assign xfer_p0 = |(ready_p0 & bus.req_valid);

  // Winner's address/data mux.
  always_comb begin
    addr_p0 = '0;
    data_p0 = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (win_p0 == IDW'(i)) begin
        addr_p0 = bus.req_addr[i*ADDR_W +: ADDR_W];
        data_p0 = bus.req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // Contention detect: two or more requesters valid in the same cycle.
  always_comb begin
    pop_p0 = '0;
    for (int i = 0; i < NREQ; i++) begin
      pop_p0 = pop_p0 + {2'b00, bus.req_valid[i]};
    end
    multi_p0 = (pop_p0 >= 3'd2);
  end

  // stage p1: registered write port, grant record, pointer and counter.
  // Reset clears the write port too, so an accepted-but-unwritten transfer
  // is dropped the moment rst falls.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_p1   <= 1'b0;
      addr_p1  <= '0;
      data_p1  <= '0;
      grant_p1 <= '0;
      ptr      <= '0;
      busy_q   <= '0;
    end else begin
      vld_p1 <= xfer_p0 && (addr_p0 != '0);
      if (xfer_p0) begin
        addr_p1  <= addr_p0;
        data_p1  <= data_p0;
        grant_p1 <= win_p0;
        ptr      <= ptr_nxt;
      end
      if (state == ARB && multi_p0) begin
        busy_q <= sat_inc(busy_q);
      end
    end
  end

  assign bus.req_ready = ready_p0;
  assign bus.rf_wen    = vld_p1;
  assign bus.rf_waddr  = addr_p1;
  assign bus.rf_wdata  = data_p1;
  assign grant_id      = grant_p1;
  assign busy_cnt      = busy_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
module tb_regfile_wb_arbiter;
  localparam int NREQ   = 2;
  localparam int ADDR_W = 5;
  localparam int DATA_W = 64;
  localparam int CNT_W  = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic [0:0]       grant_id;
  logic [CNT_W-1:0] busy_cnt;

  regfile_wb_arbiter_if #(.NREQ(NREQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  regfile_wb_arbiter #(
    .NREQ(NREQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus),
    .grant_id(grant_id),
    .busy_cnt(busy_cnt)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic        wen;
    logic [4:0]  addr;
    logic [63:0] data;
    logic        gid;
  } wr_t;

  typedef struct {
    logic [1:0]  v;
    logic [4:0]  a0;
    logic [63:0] d0;
    logic [4:0]  a1;
    logic [63:0] d1;
    logic [1:0]  rdy;
    logic [3:0]  busy;
  } vec_t;

  wr_t  sb[$];
  wr_t  last;
  vec_t tbl[12];

  // Requester-rule tracking: what each requester had pending at the last edge.
  logic [1:0]  pend = 2'b00;
  logic [4:0]  pa[2];
  logic [63:0] pd[2];

  function automatic vec_t mk(input logic [1:0] v, input logic [4:0] a0, input logic [63:0] d0,
                              input logic [4:0] a1, input logic [63:0] d1,
                              input logic [1:0] rdy, input logic [3:0] busy);
    vec_t r;
    r.v = v; r.a0 = a0; r.d0 = d0; r.a1 = a1; r.d1 = d1; r.rdy = rdy; r.busy = busy;
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic clear_model();
    sb.delete();
    pend = 2'b00;
    last.wen = 1'b0; last.addr = '0; last.data = '0; last.gid = 1'b0;
  endtask

  // Drive inputs (called just after a rising edge) and check the
  // valid/stable rule for requesters left waiting at the previous edge.
  task automatic drive(input logic [1:0] v, input logic [4:0] a0, input logic [63:0] d0,
                       input logic [4:0] a1, input logic [63:0] d1);
    logic [4:0]  na[2];
    logic [63:0] nd[2];
    na[0] = a0; na[1] = a1; nd[0] = d0; nd[1] = d1;
    for (int i = 0; i < 2; i++) begin
      if (pend[i]) begin
        assert (v[i] && na[i] == pa[i] && nd[i] == pd[i])
        else begin
          errors++;
          $display("FAIL requester_rule[%0d]: request withdrawn or changed before accept (t=%0t)", i, $time);
        end
      end
      pa[i] = na[i];
      pd[i] = nd[i];
    end
    bus.req_valid = v;
    bus.req_addr  = {a1, a0};
    bus.req_data  = {d1, d0};
  endtask

  // Apply one cycle's inputs, check ready, and queue the expected write-port
  // state for after the coming edge.
  task automatic cycle_start(input vec_t t, input string tag);
    drive(t.v, t.a0, t.d0, t.a1, t.d1);
    #1;
    chk({tag, " ready"}, 64'(bus.req_ready), 64'(t.rdy));
    pend = t.v & ~bus.req_ready;
    if (t.v[0] && t.rdy[0]) begin
      last.wen = (t.a0 != 5'd0); last.addr = t.a0; last.data = t.d0; last.gid = 1'b0;
    end else if (t.v[1] && t.rdy[1]) begin
      last.wen = (t.a1 != 5'd0); last.addr = t.a1; last.data = t.d1; last.gid = 1'b1;
    end else begin
      last.wen = 1'b0;
    end
    sb.push_back(last);
  endtask

  task automatic cycle_end(input logic [3:0] exp_busy, input string tag);
    wr_t e;
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      chk({tag, " scoreboard_empty"}, 64'(1), 64'(0));
    end else begin
      e = sb.pop_front();
      chk({tag, " rf_wen"},   64'(bus.rf_wen),   64'(e.wen));
      chk({tag, " rf_waddr"}, 64'(bus.rf_waddr), 64'(e.addr));
      chk({tag, " rf_wdata"}, bus.rf_wdata,      e.data);
      chk({tag, " grant_id"}, 64'(grant_id),     64'(e.gid));
    end
    chk({tag, " busy_cnt"}, 64'(busy_cnt), 64'(exp_busy));
  endtask

  // Release reset between edges with both requesters valid, then confirm
  // the two-edge hold before the first grant (req0).
  task automatic reset_release(input string tag);
    @(posedge clk);
    #1;
    rst = 1'b1;
    for (int e = 1; e <= 2; e++) begin
      @(posedge clk);
      #1;
      chk($sformatf("%s hold_edge%0d ready", tag, e), 64'(bus.req_ready), (e == 2) ? 64'(2'b01) : 64'(2'b00));
      chk($sformatf("%s hold_edge%0d rf_wen", tag, e), 64'(bus.rf_wen), 64'(0));
      chk($sformatf("%s hold_edge%0d busy", tag, e), 64'(busy_cnt), 64'(0));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = mk(2'b11, 5'd5, 64'hA,    5'd6, 64'hB,    2'b01, 4'd1);
    tbl[1]  = mk(2'b11, 5'd5, 64'hA,    5'd6, 64'hB,    2'b10, 4'd2);
    tbl[2]  = mk(2'b11, 5'd5, 64'hA,    5'd6, 64'hB,    2'b01, 4'd3);
    tbl[3]  = mk(2'b11, 5'd5, 64'hA,    5'd6, 64'hB,    2'b10, 4'd4);
    tbl[4]  = mk(2'b01, 5'd5, 64'hA,    5'd0, 64'h0,    2'b01, 4'd4);
    tbl[5]  = mk(2'b10, 5'd0, 64'h0,    5'd0, 64'hFFFF, 2'b10, 4'd4);
    tbl[6]  = mk(2'b11, 5'd7, 64'h77,   5'd8, 64'h88,   2'b01, 4'd5);
    tbl[7]  = mk(2'b10, 5'd0, 64'h0,    5'd8, 64'h88,   2'b10, 4'd5);
    tbl[8]  = mk(2'b01, 5'd3, 64'h1234, 5'd0, 64'h0,    2'b01, 4'd5);
    tbl[9]  = mk(2'b00, 5'd0, 64'h0,    5'd0, 64'h0,    2'b00, 4'd5);
    tbl[10] = mk(2'b00, 5'd0, 64'h0,    5'd0, 64'h0,    2'b00, 4'd5);
    tbl[11] = mk(2'b00, 5'd0, 64'h0,    5'd0, 64'h0,    2'b00, 4'd5);

    // Reset state
    rst = 1'b0;
    clear_model();
    drive(2'b11, 5'd5, 64'hA, 5'd6, 64'hB);
    #2;
    chk("reset ready",    64'(bus.req_ready), 64'(0));
    chk("reset rf_wen",   64'(bus.rf_wen),    64'(0));
    chk("reset rf_waddr", 64'(bus.rf_waddr),  64'(0));
    chk("reset rf_wdata", bus.rf_wdata,       64'(0));
    chk("reset grant_id", 64'(grant_id),      64'(0));
    chk("reset busy_cnt", 64'(busy_cnt),      64'(0));

    reset_release("rel1");
    pend = 2'b11;

    // Round-robin, x0 suppression, idle hold
    for (int i = 0; i < 12; i++) begin
      cycle_start(tbl[i], $sformatf("vec%0d", i));
      cycle_end(tbl[i].busy, $sformatf("vec%0d", i));
    end

    // Saturation with both requesters valid for 20 cycles
    rst = 1'b0;
    clear_model();
    drive(2'b11, 5'd5, 64'hA, 5'd6, 64'hB);
    reset_release("rel2");
    pend = 2'b11;
    for (int k = 1; k <= 20; k++) begin
      cycle_start(mk(2'b11, 5'd5, 64'hA, 5'd6, 64'hB, (k % 2 == 1) ? 2'b01 : 2'b10, 4'd0),
                  $sformatf("sat%0d", k));
      cycle_end((k < 15) ? 4'(k) : 4'd15, $sformatf("sat%0d", k));
    end

    // Asynchronous reset between edges while a write is on the port
    chk("midrst pre rf_wen",   64'(bus.rf_wen), 64'(1));
    chk("midrst pre grant_id", 64'(grant_id),   64'(1));
    #2;
    rst = 1'b0;
    #1;
    chk("midrst rf_wen",   64'(bus.rf_wen),    64'(0));
    chk("midrst busy_cnt", 64'(busy_cnt),      64'(0));
    chk("midrst grant_id", 64'(grant_id),      64'(0));
    chk("midrst ready",    64'(bus.req_ready), 64'(0));
    chk("midrst rf_waddr", 64'(bus.rf_waddr),  64'(0));
    clear_model();
    reset_release("rel3");
    pend = 2'b11;
    cycle_start(mk(2'b11, 5'd5, 64'hA, 5'd6, 64'hB, 2'b01, 4'd1), "post_rst0");
    cycle_end(4'd1, "post_rst0");
    cycle_start(mk(2'b11, 5'd5, 64'hA, 5'd6, 64'hB, 2'b10, 4'd2), "post_rst1");
    cycle_end(4'd2, "post_rst1");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
